// File: rtl/lcd_axis_pkg.sv
// Shared types for the LCD-to-AXI-Stream transmit path: capture state,
// FIFO word layout and pixel packing.
package lcd_axis_pkg;

    typedef enum logic [1:0] {
        WAIT_VS,
        ACTIVE,
        DROP
    } state_e;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [31:0] tdata;
    } fifo_word_t;

    localparam int FIFO_WORD_W = $bits(fifo_word_t);

    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever empty is low; a full FIFO accepts a push alongside a pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only read after being written and empty masks pop_data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/lcd_axis_tx.sv
// Parallel LCD video (vs/de/rgb with pixel enable) to AXI4-Stream master with
// frame-start on tuser, end-of-line on tlast, overflow drop and geometry checks.
module lcd_axis_tx
    import lcd_axis_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_ce,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [23:0] vid_rgb,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        ovf,
    output logic        geom_err,
    input  logic        clr,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] H_LEN = 16'(H_ACTIVE);
    localparam logic [15:0] V_LEN = 16'(V_ACTIVE);

    state_e      state_q, state_d;
    logic        vs_prev_q, vs_prev_d;
    logic        hold_v_q, hold_v_d;
    logic [23:0] hold_px_q, hold_px_d;
    logic        hold_sof_q, hold_sof_d;
    logic        sof_pend_q, sof_pend_d;
    logic        has_line_q, has_line_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        ovf_q, ovf_d;
    logic        geom_err_q, geom_err_d;

    logic        capture, vs_rise;
    logic        push_req, push_last, push_ok;
    logic        fifo_full, fifo_empty, fifo_pop;
    fifo_word_t  push_word, pop_word;

    assign fifo_pop = !fifo_empty && m_axis_tready;

    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        vs_prev_d   = vs_prev_q;
        hold_v_d    = hold_v_q;
        hold_px_d   = hold_px_q;
        hold_sof_d  = hold_sof_q;
        sof_pend_d  = sof_pend_q;
        has_line_d  = has_line_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        geom_err_d  = geom_err_q;
        push_req    = 1'b0;
        push_last   = 1'b0;

        capture = vid_ce && vid_de;
        vs_rise = vid_ce && vid_vs && !vs_prev_q;
        if (vid_ce) begin
            vs_prev_d = vid_vs;
        end

        // Clear first so that any set later in this cycle wins.
        if (clr) begin
            ovf_d      = 1'b0;
            geom_err_d = 1'b0;
        end

        // The held pixel leaves as end-of-line on de-low or a new frame,
        // otherwise as a mid-line pixel when the next one arrives.
        if (state_q == ACTIVE && hold_v_q) begin
            if (vs_rise || (vid_ce && !vid_de)) begin
                push_req  = 1'b1;
                push_last = 1'b1;
                hold_v_d  = 1'b0;
            end else if (capture) begin
                push_req = 1'b1;
            end
        end
        push_ok = push_req && (!fifo_full || m_axis_tready);

        if (push_req && !push_ok) begin
            ovf_d    = 1'b1;
            hold_v_d = 1'b0;
            state_d  = DROP;
        end else if (push_ok) begin
            if (push_last) begin
                if ((pix_cnt_q + 16'd1) != H_LEN) begin
                    geom_err_d = 1'b1;
                end
                pix_cnt_d  = '0;
                line_cnt_d = line_cnt_q + 16'd1;
                has_line_d = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 16'd1;
            end
        end

        if (vs_rise) begin
            if (state_q == ACTIVE && line_cnt_d != V_LEN) begin
                geom_err_d = 1'b1;
            end
            if (has_line_d) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            has_line_d = 1'b0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            sof_pend_d = 1'b1;
            state_d    = ACTIVE;
        end

        if (capture && state_d == ACTIVE) begin
            hold_v_d   = 1'b1;
            hold_px_d  = vid_rgb;
            hold_sof_d = sof_pend_d;
            sof_pend_d = 1'b0;
        end

        push_word.tuser = hold_sof_q;
        push_word.tlast = push_last;
        push_word.tdata = pack_pixel(hold_px_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_VS;
            vs_prev_q   <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_px_q   <= '0;
            hold_sof_q  <= 1'b0;
            sof_pend_q  <= 1'b0;
            has_line_q  <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            geom_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            hold_v_q    <= hold_v_d;
            hold_px_q   <= hold_px_d;
            hold_sof_q  <= hold_sof_d;
            sof_pend_q  <= sof_pend_d;
            has_line_q  <= has_line_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            geom_err_q  <= geom_err_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (FIFO_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = pop_word.tdata;
    assign m_axis_tuser  = pop_word.tuser;
    assign m_axis_tlast  = pop_word.tlast;
    assign ovf           = ovf_q;
    assign geom_err      = geom_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
